// File: rtl/fp_divider.sv
// fp_divider: sequential IEEE-754 single-precision divider, Result = A / B.
// Restoring division produces one quotient bit per cycle. Subnormal inputs are
// flushed to signed zero, and no subnormal results are produced.
// Build macro FP_DIV_RNE_EN selects round-to-nearest-even. When it is not
// defined, the quotient is truncated (round toward zero).
//
// state   | meaning
// IDLE    | waiting for load; operands are latched on accept
// UNPACK  | classify operands, set up divider and tentative exponent
// SPECIAL | register NaN/inf/zero result (2-cycle path)
// DIV     | one restoring iteration per cycle, 26 in total
// ROUND   | normalise, round, range-check, register result
module fp_divider #(
  parameter int N     = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Result,
  output logic         valid,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int MW = MAN_W + 1;  // significand including the hidden one
  localparam int QW = MAN_W + 3;  // quotient: integer bit, 23 fraction, guard, extra
  localparam int EW = EXP_W + 2;  // signed exponent with overflow/underflow headroom
  localparam int CW = 5;

  localparam logic [CW-1:0]        ITER_LAST = CW'(QW - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
  localparam logic signed [EW-1:0] E_MAX     = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO    = '0;
  localparam logic signed [EW-1:0] E_ONE     = EW'(1);
  localparam logic signed [EW-1:0] E_BIAS    = EW'(BIAS);
  localparam logic [N-1:0]         QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_SPECIAL,
    S_DIV,
    S_ROUND
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]         a_q, a_d;
  logic [N-1:0]         b_q, b_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [MW-1:0]        div_q, div_d;
  logic [QW-1:0]        rem_q, rem_d;
  logic [QW-1:0]        quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N-1:0]         result_q, result_d;
  logic                 dbz_q, dbz_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  // Operand fields, taken from the latched copies so A/B may change while busy
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa     = a_q[N-1];
  assign sb     = b_q[N-1];
  assign ea     = a_q[N-2 -: EXP_W];
  assign eb     = b_q[N-2 -: EXP_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);

  logic         spec_sign;
  logic [N-1:0] spec_res;
  logic         spec_dbz;
  logic         is_special;

  // Special-case classification in priority order
  always_comb begin
    spec_sign  = sa ^ sb;
    spec_res   = '0;
    spec_dbz   = 1'b0;
    is_special = 1'b1;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
    end else if (a_inf) begin
      spec_res = {spec_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf || a_zero) begin
      spec_res = {spec_sign, {(N-1){1'b0}}};
    end else if (b_zero) begin
      spec_res = {spec_sign, EXP_ONES, {MAN_W{1'b0}}};
      spec_dbz = 1'b1;
    end else begin
      is_special = 1'b0;
    end
  end

  logic [QW-1:0] div_ext;
  logic [QW-1:0] rem_next;
  logic          q_bit;

  // One restoring step: subtract the divisor when it fits
  always_comb begin
    div_ext  = {2'b00, div_q};
    q_bit    = (rem_q >= div_ext);
    rem_next = q_bit ? (rem_q - div_ext) : rem_q;
  end

  logic signed [EW-1:0] e_r;
  logic [MW-1:0]        mant_r;
  logic                 guard, sticky;
  logic [N-1:0]         rnd_res;
  logic                 rnd_unused;
`ifdef FP_DIV_RNE_EN
  logic [MW:0]          mant_inc;
`endif

  // Normalise the quotient, round, then clamp to inf or zero
  always_comb begin
    e_r    = exp_q;
    mant_r = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    if (quo_q[QW-1]) begin
      mant_r = quo_q[QW-1:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
    end else begin
      mant_r = quo_q[QW-2:1];
      guard  = quo_q[0];
      sticky = |rem_q;
      e_r    = exp_q - E_ONE;
    end
`ifdef FP_DIV_RNE_EN
    mant_inc = {1'b0, mant_r} + {{MW{1'b0}}, guard & (sticky | mant_r[0])};
    if (mant_inc[MW]) begin
      mant_r = {1'b1, {MAN_W{1'b0}}};
      e_r    = e_r + E_ONE;
    end else begin
      mant_r = mant_inc[MW-1:0];
    end
`endif
    // Hidden bit is implied in the packed result; guard/sticky are dead under truncation
    rnd_unused = ^{guard, sticky, mant_r[MW-1]};
    if (e_r >= E_MAX) begin
      rnd_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
    end else if (e_r <= E_ZERO) begin
      rnd_res = {sign_q, {(N-1){1'b0}}};
    end else begin
      rnd_res = {sign_q, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (load) state_d = S_UNPACK;
      S_UNPACK:  state_d = is_special ? S_SPECIAL : S_DIV;
      S_SPECIAL: state_d = S_IDLE;
      S_DIV:     if (cnt_q == '0) state_d = S_ROUND;
      S_ROUND:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output register updates per state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          a_d    = A;
          b_d    = B;
          busy_d = 1'b1;
        end
      end
      S_UNPACK: begin
        sign_d = sa ^ sb;
        exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
        div_d  = {1'b1, fb};
        rem_d  = {2'b00, 1'b1, fa};
        quo_d  = '0;
        cnt_d  = ITER_LAST;
      end
      S_SPECIAL: begin
        result_d = spec_res;
        dbz_d    = spec_dbz;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
      end
      S_DIV: begin
        rem_d = rem_next << 1;
        quo_d = {quo_q[QW-2:0], q_bit};
        cnt_d = cnt_q - 1'b1;
      end
      S_ROUND: begin
        result_d = rnd_res;
        dbz_d    = 1'b0;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign Result      = result_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule
